// File: rtl/rob_multi_retire.sv
// Reorder buffer: multi-lane in-order dispatch, out-of-order completion and in-order
// multi-lane retire. A retiring mispredict or a blocking exception flushes the whole buffer.
module rob_multi_retire #(
    parameter int NUM_ROB_ENTS = 64,
    parameter int DISP_WIDTH   = 2,
    parameter int RETIRE_WIDTH = 4,
    parameter int NUM_FUS      = 4,
    parameter int NUM_AREGS    = 32,
    parameter int NUM_PREGS    = 128,
    localparam int IW = $clog2(NUM_ROB_ENTS),
    localparam int AW = $clog2(NUM_AREGS),
    localparam int PW = $clog2(NUM_PREGS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DISP_WIDTH-1:0]                disp_valid,
    input  logic [DISP_WIDTH-1:0][AW-1:0]        disp_dst_areg,
    input  logic [DISP_WIDTH-1:0][PW-1:0]        disp_dst_preg,
    input  logic [DISP_WIDTH-1:0][31:0]          disp_pc,
    output logic                                 disp_ready,
    output logic [DISP_WIDTH-1:0][IW-1:0]        disp_rob_idx,
    input  logic [NUM_FUS-1:0]                   cmpl_valid,
    input  logic [NUM_FUS-1:0][IW-1:0]           cmpl_rob_idx,
    input  logic [NUM_FUS-1:0]                   cmpl_exception,
    input  logic [NUM_FUS-1:0]                   cmpl_br_mispred,
    output logic [RETIRE_WIDTH-1:0]              ret_valid,
    output logic [RETIRE_WIDTH-1:0][AW-1:0]      ret_dst_areg,
    output logic [RETIRE_WIDTH-1:0][PW-1:0]      ret_dst_preg,
    output logic [RETIRE_WIDTH-1:0][31:0]        ret_pc,
    output logic                                 flush_valid,
    output logic                                 flush_is_exc,
    output logic [31:0]                          flush_pc,
    output logic [IW:0]                          rob_count
);

    logic [NUM_ROB_ENTS-1:0] ent_valid, ent_cmpl, ent_exc, ent_br;
    logic [NUM_ROB_ENTS-1:0] valid_nxt, cmpl_nxt, exc_nxt, br_nxt;
    logic [NUM_ROB_ENTS-1:0] cmpl_set, exc_set, br_set;
    logic [AW-1:0]           ent_areg [NUM_ROB_ENTS];
    logic [PW-1:0]           ent_preg [NUM_ROB_ENTS];
    logic [31:0]             ent_pc   [NUM_ROB_ENTS];
    logic [IW-1:0]           head, tail, scan_idx, new_head;
    logic [IW:0]             count, free_cnt, alloc_cnt, alloc_n, ret_cnt;
    logic                    scan_stop;

    assign free_cnt   = (IW+1)'(NUM_ROB_ENTS) - count;
    assign disp_ready = (free_cnt >= (IW+1)'(DISP_WIDTH)) && !flush_valid;
    assign alloc_n    = disp_ready ? alloc_cnt : '0;
    assign new_head   = head + ret_cnt[IW-1:0];
    assign rob_count  = count;

    always_comb begin
        alloc_cnt = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            disp_rob_idx[k] = tail + alloc_cnt[IW-1:0];
            if (disp_valid[k]) alloc_cnt = alloc_cnt + 1'b1;
        end
    end

    // Scan from head; an exception blocks without retiring, a mispredict retires and closes the group.
    always_comb begin
        ret_valid    = '0;
        ret_dst_areg = '0;
        ret_dst_preg = '0;
        ret_pc       = '0;
        flush_valid  = 1'b0;
        flush_is_exc = 1'b0;
        flush_pc     = '0;
        ret_cnt      = '0;
        scan_stop    = 1'b0;
        scan_idx     = head;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            scan_idx = head + IW'(i);
            if (!scan_stop) begin
                if (!(ent_valid[scan_idx] && ent_cmpl[scan_idx])) begin
                    scan_stop = 1'b1;
                end else if (ent_exc[scan_idx]) begin
                    flush_valid  = 1'b1;
                    flush_is_exc = 1'b1;
                    flush_pc     = ent_pc[scan_idx];
                    scan_stop    = 1'b1;
                end else begin
                    ret_valid[i]    = 1'b1;
                    ret_dst_areg[i] = ent_areg[scan_idx];
                    ret_dst_preg[i] = ent_preg[scan_idx];
                    ret_pc[i]       = ent_pc[scan_idx];
                    ret_cnt         = ret_cnt + 1'b1;
                    if (ent_br[scan_idx]) begin
                        flush_valid = 1'b1;
                        flush_pc    = ent_pc[scan_idx];
                        scan_stop   = 1'b1;
                    end
                end
            end
        end
    end

    // Ports hitting the same entry merge their flags here before the register update.
    always_comb begin
        cmpl_set = '0;
        exc_set  = '0;
        br_set   = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            if (cmpl_valid[f]) begin
                cmpl_set[cmpl_rob_idx[f]] = 1'b1;
                exc_set[cmpl_rob_idx[f]]  = exc_set[cmpl_rob_idx[f]] | cmpl_exception[f];
                br_set[cmpl_rob_idx[f]]   = br_set[cmpl_rob_idx[f]] | cmpl_br_mispred[f];
            end
        end
    end

    always_comb begin
        valid_nxt = ent_valid;
        cmpl_nxt  = ent_cmpl | (cmpl_set & ent_valid);
        exc_nxt   = ent_exc | (exc_set & ent_valid);
        br_nxt    = ent_br | (br_set & ent_valid);
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (ret_valid[i]) valid_nxt[head + IW'(i)] = 1'b0;
        end
        if (disp_ready) begin
            for (int k = 0; k < DISP_WIDTH; k++) begin
                if (disp_valid[k]) begin
                    valid_nxt[disp_rob_idx[k]] = 1'b1;
                    cmpl_nxt[disp_rob_idx[k]]  = 1'b0;
                    exc_nxt[disp_rob_idx[k]]   = 1'b0;
                    br_nxt[disp_rob_idx[k]]    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_cmpl  <= '0;
            ent_exc   <= '0;
            ent_br    <= '0;
        end else if (flush_valid) begin
            head      <= new_head;
            tail      <= new_head;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            head      <= new_head;
            tail      <= tail + alloc_n[IW-1:0];
            count     <= count + alloc_n - ret_cnt;
            ent_valid <= valid_nxt;
            ent_cmpl  <= cmpl_nxt;
            ent_exc   <= exc_nxt;
            ent_br    <= br_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (disp_ready) begin
            for (int k = 0; k < DISP_WIDTH; k++) begin
                if (disp_valid[k]) begin
                    ent_areg[disp_rob_idx[k]] <= disp_dst_areg[k];
                    ent_preg[disp_rob_idx[k]] <= disp_dst_preg[k];
                    ent_pc[disp_rob_idx[k]]   <= disp_pc[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_retire.sv
// Bench for rob_multi_retire: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_multi_retire;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           disp_valid;
    logic [1:0][4:0]      disp_dst_areg;
    logic [1:0][6:0]      disp_dst_preg;
    logic [1:0][31:0]     disp_pc;
    logic                 disp_ready;
    logic [1:0][5:0]      disp_rob_idx;
    logic [3:0]           cmpl_valid;
    logic [3:0][5:0]      cmpl_rob_idx;
    logic [3:0]           cmpl_exception;
    logic [3:0]           cmpl_br_mispred;
    logic [3:0]           ret_valid;
    logic [3:0][4:0]      ret_dst_areg;
    logic [3:0][6:0]      ret_dst_preg;
    logic [3:0][31:0]     ret_pc;
    logic                 flush_valid;
    logic                 flush_is_exc;
    logic [31:0]          flush_pc;
    logic [6:0]           rob_count;

    rob_multi_retire dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_dst_areg(disp_dst_areg), .disp_dst_preg(disp_dst_preg),
        .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
        .cmpl_valid(cmpl_valid), .cmpl_rob_idx(cmpl_rob_idx), .cmpl_exception(cmpl_exception),
        .cmpl_br_mispred(cmpl_br_mispred),
        .ret_valid(ret_valid), .ret_dst_areg(ret_dst_areg), .ret_dst_preg(ret_dst_preg),
        .ret_pc(ret_pc), .flush_valid(flush_valid), .flush_is_exc(flush_is_exc),
        .flush_pc(flush_pc), .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        int          areg;
        int          preg;
        logic [31:0] pc;
        bit          cmpl;
        bit          exc;
        bit          br;
    } ent_t;

    ent_t        rob[$];
    int          m_head, m_tail;
    int          e_nret;
    bit          e_flush, e_exc, e_ready;
    logic [31:0] e_fpc;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          nfull;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs from the in-order queue: walk the oldest entries until one is
    // incomplete, an exception, or the group is full; a mispredict closes the group.
    task automatic model_eval();
        int  n;
        bit  stop;
        e_nret = 0; e_flush = 0; e_exc = 0; e_fpc = '0; stop = 0;
        n = (rob.size() < 4) ? rob.size() : 4;
        for (int i = 0; i < n; i++) begin
            if (!stop) begin
                if (!rob[i].cmpl) stop = 1;
                else if (rob[i].exc) begin e_flush = 1; e_exc = 1; e_fpc = rob[i].pc; stop = 1; end
                else begin
                    e_nret++;
                    if (rob[i].br) begin e_flush = 1; e_fpc = rob[i].pc; stop = 1; end
                end
            end
        end
        e_ready = (64 - rob.size() >= 2) && !e_flush;
    endtask

    task automatic check_all();
        int below = 0;
        chk("rob_count", rob_count, rob.size());
        chk("disp_ready", disp_ready, e_ready);
        for (int k = 0; k < 2; k++) begin
            chk("disp_rob_idx", disp_rob_idx[k], (m_tail + below) % 64);
            if (disp_valid[k]) below++;
        end
        chk("flush_valid", flush_valid, e_flush);
        if (e_flush) begin
            chk("flush_is_exc", flush_is_exc, e_exc);
            chk("flush_pc", flush_pc, e_fpc);
        end
        for (int i = 0; i < 4; i++) begin
            chk("ret_valid", ret_valid[i], (i < e_nret) ? 1 : 0);
            if (i < e_nret) begin
                chk("ret_dst_areg", ret_dst_areg[i], rob[i].areg);
                chk("ret_dst_preg", ret_dst_preg[i], rob[i].preg);
                chk("ret_pc", ret_pc[i], rob[i].pc);
            end
        end
    endtask

    task automatic model_commit();
        ent_t e;
        if (rst) begin
            rob.delete(); m_head = 0; m_tail = 0;
            return;
        end
        for (int i = 0; i < e_nret; i++) rob.delete(0);
        m_head = (m_head + e_nret) % 64;
        if (e_flush) begin
            rob.delete(); m_tail = m_head;
            return;
        end
        for (int f = 0; f < 4; f++) begin
            if (cmpl_valid[f]) begin
                for (int j = 0; j < rob.size(); j++) begin
                    if (rob[j].idx == int'(cmpl_rob_idx[f])) begin
                        rob[j].cmpl = 1;
                        rob[j].exc  = rob[j].exc | cmpl_exception[f];
                        rob[j].br   = rob[j].br | cmpl_br_mispred[f];
                    end
                end
            end
        end
        if (e_ready) begin
            for (int k = 0; k < 2; k++) begin
                if (disp_valid[k]) begin
                    e.idx = m_tail; e.areg = disp_dst_areg[k]; e.preg = disp_dst_preg[k];
                    e.pc = disp_pc[k]; e.cmpl = 0; e.exc = 0; e.br = 0;
                    rob.push_back(e);
                    m_tail = (m_tail + 1) % 64;
                end
            end
        end
    endtask

    // Inputs are set just after a falling edge; this checks, crosses the rising edge, and returns at the next falling edge.
    task automatic cycle();
        #1;
        model_eval();
        check_all();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic clr_in();
        disp_valid = '0; disp_dst_areg = '0; disp_dst_preg = '0; disp_pc = '0;
        cmpl_valid = '0; cmpl_rob_idx = '0; cmpl_exception = '0; cmpl_br_mispred = '0;
    endtask

    task automatic disp_pair(input logic [31:0] pc0);
        disp_valid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            disp_dst_areg[k] = 5'($urandom);
            disp_dst_preg[k] = 7'($urandom);
            disp_pc[k]       = pc0 + 32'(4 * k);
        end
    endtask

    task automatic set_cmpl(input int f, input int idx, input bit exc, input bit br);
        cmpl_valid[f] = 1'b1;
        cmpl_rob_idx[f] = 6'(idx);
        cmpl_exception[f] = exc;
        cmpl_br_mispred[f] = br;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        @(posedge clk);
        rob.delete(); m_head = 0; m_tail = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        clr_in();
        do_reset();

        // reset values
        #1;
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_flush_valid", flush_valid, 0);
        chk("rst_flush_is_exc", flush_is_exc, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_rob_count", rob_count, 0);
        chk("rst_disp_ready", disp_ready, 1);
        cycle();

        // fill and drain
        for (int n = 0; n < 32; n++) begin
            clr_in(); disp_pair(32'h1000 + 32'(8 * n)); cycle();
        end
        clr_in();
        #1;
        chk("fill_count", rob_count, 64);
        chk("fill_ready", disp_ready, 0);
        nfull = 0;
        for (int c = 0; c < 16; c++) begin
            clr_in();
            for (int f = 0; f < 4; f++) set_cmpl(f, 4 * c + f, 0, 0);
            #1;
            if (c == 1) begin
                chk("drain_first_pc0", ret_pc[0], 32'h1000);
                chk("drain_first_pc3", ret_pc[3], 32'h100C);
            end
            if (ret_valid == 4'hF) nfull++;
            cycle();
        end
        clr_in();
        #1;
        if (ret_valid == 4'hF) nfull++;
        cycle();
        #1;
        chk("drain_full_groups", nfull, 16);
        chk("drain_count", rob_count, 0);
        cycle();

        // wrap
        do_reset();
        for (int n = 0; n < 31; n++) begin
            clr_in(); disp_pair(32'h7000 + 32'(8 * n)); cycle();
            clr_in(); set_cmpl(0, 2 * n, 0, 0); set_cmpl(1, 2 * n + 1, 0, 0); cycle();
        end
        clr_in(); cycle();
        disp_pair(32'h7F00);
        #1;
        chk("wrap_idx0_a", disp_rob_idx[0], 62);
        chk("wrap_idx1_a", disp_rob_idx[1], 63);
        cycle();
        disp_pair(32'h7F08);
        #1;
        chk("wrap_idx0_b", disp_rob_idx[0], 0);
        chk("wrap_idx1_b", disp_rob_idx[1], 1);
        cycle();

        // out-of-order completion
        do_reset();
        disp_pair(32'h3000); cycle();
        disp_pair(32'h3008); cycle();
        clr_in(); set_cmpl(0, 1, 0, 0); set_cmpl(1, 2, 0, 0); set_cmpl(2, 3, 0, 0); cycle();
        clr_in();
        #1;
        chk("ooo_blocked", ret_valid, 0);
        cycle();
        set_cmpl(3, 0, 0, 0); cycle();
        clr_in();
        #1;
        chk("ooo_retire4", ret_valid, 4'b1111);
        cycle();
        #1;
        chk("ooo_count", rob_count, 0);
        cycle();

        // mispredict
        do_reset();
        disp_pair(32'h4000); cycle();
        disp_pair(32'h4008); cycle();
        clr_in();
        set_cmpl(0, 0, 0, 0); set_cmpl(1, 1, 0, 1); set_cmpl(2, 2, 0, 0); set_cmpl(3, 3, 0, 0);
        cycle();
        clr_in();
        #1;
        chk("br_ret_valid", ret_valid, 4'b0011);
        chk("br_flush", flush_valid, 1);
        chk("br_is_exc", flush_is_exc, 0);
        chk("br_pc", flush_pc, 32'h4004);
        cycle();
        #1;
        chk("br_count", rob_count, 0);
        chk("br_tail", disp_rob_idx[0], 2);
        cycle();

        // exception with dispatch in the flush cycle
        do_reset();
        disp_pair(32'h5000); cycle();
        disp_pair(32'h5008); cycle();
        clr_in();
        set_cmpl(0, 0, 0, 0); set_cmpl(1, 1, 0, 0); set_cmpl(2, 2, 1, 0); set_cmpl(3, 3, 0, 0);
        cycle();
        clr_in(); disp_pair(32'h5100);
        #1;
        chk("exc_ret_valid", ret_valid, 4'b0011);
        chk("exc_flush", flush_valid, 1);
        chk("exc_is_exc", flush_is_exc, 1);
        chk("exc_pc", flush_pc, 32'h5008);
        chk("exc_disp_ready", disp_ready, 0);
        cycle();
        clr_in();
        #1;
        chk("exc_count", rob_count, 0);
        chk("exc_tail", disp_rob_idx[0], 2);
        cycle();

        // reset mid-stream with 10 live entries and a retire pending
        do_reset();
        for (int n = 0; n < 5; n++) begin
            clr_in(); disp_pair(32'h6000 + 32'(8 * n)); cycle();
        end
        clr_in();
        for (int f = 0; f < 4; f++) set_cmpl(f, f, 0, 0);
        cycle();
        disp_pair(32'h6100);
        for (int f = 0; f < 4; f++) set_cmpl(f, 4 + f, f == 1, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0; clr_in();
        #1;
        chk("mid_rst_ret_valid", ret_valid, 0);
        chk("mid_rst_flush_valid", flush_valid, 0);
        chk("mid_rst_flush_is_exc", flush_is_exc, 0);
        chk("mid_rst_flush_pc", flush_pc, 0);
        chk("mid_rst_count", rob_count, 0);
        chk("mid_rst_ready", disp_ready, 1);
        cycle();

        // randomized traffic, alternating fill-heavy and drain-heavy phases
        for (int i = 0; i < 3000; i++) begin
            bit fill;
            clr_in();
            fill = ((i / 250) % 2) == 0;
            rst = ($urandom_range(0, 399) == 0);
            for (int k = 0; k < 2; k++) begin
                disp_valid[k]    = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                disp_dst_areg[k] = 5'($urandom);
                disp_dst_preg[k] = 7'($urandom);
                disp_pc[k]       = $urandom;
            end
            for (int f = 0; f < 4; f++) begin
                if ($urandom_range(0, fill ? 5 : 1) == 0) begin
                    cmpl_valid[f] = 1'b1;
                    if (rob.size() > 0 && $urandom_range(0, 7) != 0)
                        cmpl_rob_idx[f] = 6'(rob[$urandom_range(0, rob.size() - 1)].idx);
                    else
                        cmpl_rob_idx[f] = 6'($urandom_range(0, 63));
                    cmpl_exception[f]  = ($urandom_range(0, 59) == 0);
                    cmpl_br_mispred[f] = ($urandom_range(0, 59) == 0);
                end
            end
            cycle();
        end
        rst = 1'b0;
        clr_in();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rob_multi_retire.md
ROB_MULTI_RETIRE -- requirements
Module: rob_multi_retire

Interface
REQ-001 SHALL have parameter NUM_ROB_ENTS, default 64, ROB depth; power of 2, at least 4.
REQ-002 SHALL have parameter DISP_WIDTH, default 2, allocation lanes per cycle.
REQ-003 SHALL have parameter RETIRE_WIDTH, default 4, retire lanes per cycle.
REQ-004 SHALL have parameter NUM_FUS, default 4, completion ports.
REQ-005 SHALL have parameters NUM_AREGS, default 32, and NUM_PREGS, default 128; IW = $clog2(NUM_ROB_ENTS).
REQ-006 SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- disp_valid  in  DISP_WIDTH  per-lane allocate request.
- disp_dst_areg  in  DISP_WIDTH x $clog2(NUM_AREGS)  architectural destination.
- disp_dst_preg  in  DISP_WIDTH x $clog2(NUM_PREGS)  physical destination.
- disp_pc  in  DISP_WIDTH x 32  instruction PC.
- disp_ready  out  1  all DISP_WIDTH lanes can be accepted this cycle.
- disp_rob_idx  out  DISP_WIDTH x IW  index assigned to each lane, combinational.
- cmpl_valid  in  NUM_FUS  completion strobe.
- cmpl_rob_idx  in  NUM_FUS x IW  completing entry.
- cmpl_exception, cmpl_br_mispred  in  NUM_FUS each  completion flags.
- ret_valid  out  RETIRE_WIDTH  retiring lanes, oldest in lane 0.
- ret_dst_areg, ret_dst_preg, ret_pc  out  per lane  fields of the retiring entries.
- flush_valid  out  1  pipeline flush.
- flush_is_exc  out  1  flush cause: 1 = exception, 0 = mispredict.
- flush_pc  out  32  PC of the offending entry.
- rob_count  out  IW+1  number of occupied entries.

Function
REQ-007 SHALL keep, per entry, valid, complete, exception, br_mispred, dst_areg, dst_preg and pc, plus a head pointer, a tail pointer and a count; both pointers wrap modulo NUM_ROB_ENTS.
REQ-008 SHALL drive disp_ready = (NUM_ROB_ENTS - count >= DISP_WIDTH) and not flush_valid.
REQ-009 SHALL, when disp_ready = 1, allocate one entry per set disp_valid lane, in lane order starting at tail, skipping clear lanes; disp_rob_idx[k] = tail + (number of set lanes below k).
REQ-010 SHALL ignore all disp_valid lanes when disp_ready = 0, with no state change from dispatch.
REQ-011 SHALL, for each cmpl_valid port, set complete on the addressed entry and OR in exception and br_mispred at the next edge; a completion to an invalid entry SHALL be ignored.
REQ-012 SHALL OR the flags when two ports complete the same index in one cycle.
REQ-013 SHALL form the retire group combinationally from registered state: consecutive entries from head, up to RETIRE_WIDTH, that are valid and complete.
- An exception entry stops the group and is excluded from it.
- A br_mispred entry is included in the group as its last member.
REQ-014 SHALL drive ret_valid lanes contiguously from lane 0; retired entries are invalidated and head advances by the group size at the next edge.
REQ-015 SHALL assert flush_valid = 1, flush_is_exc = 0 and flush_pc = that entry's pc when a br_mispred entry is in the retire group.
REQ-016 SHALL assert flush_valid = 1, flush_is_exc = 1 and flush_pc = that entry's pc when the first non-retired entry in scan order is valid, complete and has exception set.
- Entries older than it still retire in the same cycle.
- The exception entry itself does not retire.
REQ-017 SHALL, at the edge ending a flush cycle, invalidate all entries, set tail = new head (old head + retired count) and count = 0; completions arriving in that cycle SHALL be discarded.
REQ-018 SHALL update count as count + allocated - retired in non-flush cycles, covering simultaneous dispatch and retire, including while full.
REQ-019 SHALL have zero cycles of dispatch-to-index latency; an entry can retire no earlier than 1 cycle after its completion edge.

Reset
REQ-020 SHALL, while rst = 1 at an edge, clear head, tail, count and every entry valid, complete and flag bit.
REQ-021 SHALL drive after reset: ret_valid = 0, flush_valid = 0, flush_is_exc = 0, flush_pc = 0, rob_count = 0, disp_ready = 1.
REQ-022 SHALL discard any in-flight dispatch, completion, retire or flush when reset is asserted mid-operation.

Verification
REQ-023 SHALL cover fill and drain with defaults: 32 dispatch pairs -> rob_count = 64 and disp_ready = 0; complete all -> 4 retires per cycle in PC order; rob_count = 0 after 16 cycles.
REQ-024 SHALL cover wrap: head = tail = 62, dispatch 2 -> disp_rob_idx = {62, 63}; next pair -> {0, 1}.
REQ-025 SHALL cover out-of-order completion: complete idx 1, 2, 3 before 0 -> no retire; complete 0 -> 4 lanes retire the next cycle.
REQ-026 SHALL cover mispredict: idx 1 br_mispred, idx 0..3 complete -> ret_valid = 0b0011 and flush_is_exc = 0 with idx 1's PC; next cycle rob_count = 0 and tail = 2.
REQ-027 SHALL cover exception: idx 2 exception, idx 0..3 complete -> ret_valid = 0b0011 and flush_is_exc = 1 with idx 2's PC; simultaneous dispatch is ignored.
REQ-028 SHALL cover reset mid-stream: rst with 10 entries live -> all outputs at reset values the next cycle.
